// File: rtl/serial_pattern_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : serial_pattern_pkg                                           |
// | Description : Shared types and default parameter values for the serial    |
// |               pattern generator.                                           |
// |               - state_e      : transfer FSM encoding (IDLE, SEND, FLUSH)    |
// |               - DEF_W        : default maximum pattern length in bits       |
// |               - DEF_REP_W    : default width of the repeat field            |
// |               - DEF_IDLE_BIT : default level driven while not transmitting  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int   DEF_W        = 8;
  localparam int   DEF_REP_W    = 4;
  localparam logic DEF_IDLE_BIT = 1'b0;

endpackage : serial_pattern_pkg
`default_nettype wire

// File: rtl/serial_pattern_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_pattern_generator                                     |
// | Description : Accepts a parallel pattern over a valid/ready handshake and  |
// |               transmits it serially, oldest bit first, repeated            |
// |               load_repeat+1 times with no gaps between passes or between   |
// |               back-to-back transfers.                                      |
// | Ports       : clk          - system clock, posedge                         |
// |               rst          - synchronous active-high reset                 |
// |               load_valid   - pattern request valid                         |
// |               load_ready   - block can accept a pattern this cycle         |
// |               load_pattern - pattern, bit [load_len-1] sent first          |
// |               load_len     - number of bits per pass, legal 1..W           |
// |               load_repeat  - extra passes (total = load_repeat+1)          |
// |               out_bit      - current serial bit (registered)               |
// |               out_valid    - out_bit carries a pattern bit (registered)    |
// |               done         - pulse with the final bit of the final pass,   |
// |                              or the single FLUSH cycle of an illegal len   |
// |               busy         - a transfer is in progress                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module serial_pattern_generator
  import serial_pattern_pkg::*;
#(
  parameter int   W        = DEF_W,
  parameter int   LEN_W    = $clog2(W + 1),
  parameter int   REP_W    = DEF_REP_W,
  parameter logic IDLE_BIT = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [W-1:0]     load_pattern,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_repeat,
  output logic             out_bit,
  output logic             out_valid,
  output logic             done,
  output logic             busy
);

  localparam logic [LEN_W-1:0] C_LEN_MAX = LEN_W'(W);
  localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);
  localparam logic [REP_W-1:0] C_REP_ONE = REP_W'(1);

  state_e             state_q;
  logic [W-1:0]       pat_q;      // captured pattern, left-aligned (first bit at MSB)
  logic [W-1:0]       shreg_q;    // bits still to be sent in this pass, next at MSB
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;      // bits remaining after the one on out_bit
  logic [REP_W-1:0]   pass_q;     // passes remaining after the current one
  logic               out_bit_q;
  logic               out_valid_q;
  logic               done_q;

  logic               w_last_bit;
  logic               w_accept;
  logic               w_len_ok;
  logic [LEN_W-1:0]   w_shamt;
  logic [W-1:0]       w_aligned;

  // The final bit of the final pass is on the line: the slot where a new
  // transfer may be taken so its first bit follows with no gap.
  assign w_last_bit = (state_q == ST_SEND) && (idx_q == '0) && (pass_q == '0);

  assign load_ready = !rst && ((state_q == ST_IDLE) || w_last_bit);
  assign w_accept   = load_valid && load_ready;
  assign w_len_ok   = (load_len != '0) && (load_len <= C_LEN_MAX);

  // Left-align the pattern so the first bit to send always sits at the MSB
  // and the shift register only ever shifts left.
  assign w_shamt    = C_LEN_MAX - load_len;
  assign w_aligned  = load_pattern << w_shamt;

  assign busy       = (state_q != ST_IDLE);
  assign out_bit    = out_bit_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      shreg_q     <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      out_bit_q   <= IDLE_BIT;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (w_accept) begin
        if (w_len_ok) begin
          state_q     <= ST_SEND;
          pat_q       <= w_aligned;
          shreg_q     <= w_aligned << 1;
          len_q       <= load_len;
          idx_q       <= load_len - C_LEN_ONE;
          pass_q      <= load_repeat;
          out_bit_q   <= w_aligned[W-1];
          out_valid_q <= 1'b1;
          // A one-bit, single-pass transfer ends on its first bit.
          done_q      <= (load_len == C_LEN_ONE) && (load_repeat == '0);
        end else begin
          // Illegal length: swallow the request, signal completion once.
          state_q     <= ST_FLUSH;
          out_bit_q   <= IDLE_BIT;
          out_valid_q <= 1'b0;
          done_q      <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_SEND: begin
            if (idx_q != '0) begin
              out_bit_q <= shreg_q[W-1];
              shreg_q   <= shreg_q << 1;
              idx_q     <= idx_q - C_LEN_ONE;
              done_q    <= (idx_q == C_LEN_ONE) && (pass_q == '0);
            end else if (pass_q != '0) begin
              // Start the next pass straight from the captured pattern.
              out_bit_q <= pat_q[W-1];
              shreg_q   <= pat_q << 1;
              idx_q     <= len_q - C_LEN_ONE;
              pass_q    <= pass_q - C_REP_ONE;
              done_q    <= (len_q == C_LEN_ONE) && (pass_q == C_REP_ONE);
            end else begin
              state_q     <= ST_IDLE;
              out_bit_q   <= IDLE_BIT;
              out_valid_q <= 1'b0;
            end
          end
          ST_FLUSH: begin
            state_q     <= ST_IDLE;
            out_bit_q   <= IDLE_BIT;
            out_valid_q <= 1'b0;
          end
          default: begin
            state_q     <= ST_IDLE;
            out_bit_q   <= IDLE_BIT;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : serial_pattern_generator
`default_nettype wire
